// File: rtl/dram_cache_fill_writer.sv
// dram_cache_fill_writer
// Takes line fills (dirty writes) and refills (clean lines from backing
// memory), packs them into the in-DRAM {valid, dirty, tag, blank, data} word
// and writes that word to the DRAM cache controller as a single-beat AXI write.
// Only one write is in flight at a time.
// Build option: DRAM_CACHE_FILL_RR_EN selects round-robin arbitration between
// the two request ports; otherwise refill always wins over fill.
module dram_cache_fill_writer #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 512,
  parameter int ID_WIDTH     = 4,
  parameter int TAG_SIZE     = 32,
  parameter int TAG_WIDTH    = 12,
  parameter int BLANK_WIDTH  = 18,
  parameter int INDEX_WIDTH  = 14,
  parameter int OFFSET_WIDTH = 6,
  parameter int WR_ID        = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           fill_valid_i,
  output logic                           fill_ready_o,
  input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] fill_data_i,
  input  logic                           refill_valid_i,
  output logic                           refill_ready_o,
  input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] refill_data_i,
  output logic [ID_WIDTH-1:0]            awid_o,
  output logic [ADDR_WIDTH-1:0]          awaddr_o,
  output logic                           awvalid_o,
  input  logic                           awready_i,
  output logic [TAG_SIZE+DATA_WIDTH-1:0] wdata_o,
  output logic                           wlast_o,
  output logic                           wvalid_o,
  input  logic                           wready_i,
  input  logic [ID_WIDTH-1:0]            bid_i,
  input  logic [1:0]                     bresp_i,
  input  logic                           bvalid_i,
  output logic                           bready_o,
  output logic                           busy_o,
  output logic                           err_o
);

  localparam int PW = ADDR_WIDTH + DATA_WIDTH;
  localparam int WW = TAG_SIZE + DATA_WIDTH;
  // Keeps only the set-index bits of an address: that is the slot address.
  localparam logic [ADDR_WIDTH-1:0] IDX_MASK =
    {{(ADDR_WIDTH-INDEX_WIDTH-OFFSET_WIDTH){1'b0}}, {INDEX_WIDTH{1'b1}}, {OFFSET_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic                   awvalid_q, awvalid_d;
  logic                   wvalid_q, wvalid_d;
  logic                   aw_done_q, aw_done_d;
  logic                   w_done_q, w_done_d;
  logic                   err_q, err_d;
  logic [ADDR_WIDTH-1:0]  awaddr_q, awaddr_d;
  logic [WW-1:0]          wdata_q, wdata_d;

  logic                   grant_fill;
  logic                   accept;
  logic [PW-1:0]          req;
  logic [ADDR_WIDTH-1:0]  req_addr;
  logic [DATA_WIDTH-1:0]  req_data;
  logic [WW-1:0]          req_word;
  logic                   aw_fin, w_fin;
  logic                   unused_bid;

`ifdef DRAM_CACHE_FILL_RR_EN
  // Pointer low = fill has the turn, high = refill has the turn.
  logic rr_q, rr_d;
  assign grant_fill = fill_valid_i & (~refill_valid_i | ~rr_q);
`else
  assign grant_fill = fill_valid_i & ~refill_valid_i;
`endif

  assign fill_ready_o   = (state_q == S_IDLE) & fill_valid_i & grant_fill;
  assign refill_ready_o = (state_q == S_IDLE) & refill_valid_i & ~grant_fill;
  assign accept         = fill_ready_o | refill_ready_o;

  assign req      = grant_fill ? fill_data_i : refill_data_i;
  assign req_addr = req[PW-1:DATA_WIDTH];
  assign req_data = req[DATA_WIDTH-1:0];

  // A handshake counts as done once it has happened, including this cycle.
  assign aw_fin = aw_done_q | (awvalid_q & awready_i);
  assign w_fin  = w_done_q  | (wvalid_q  & wready_i);

  // Pack the granted request into the stored tag+data word; fills are dirty.
  always_comb begin
    req_word = '0;
    req_word[WW-1] = 1'b1;
    req_word[WW-2] = grant_fill;
    req_word[TAG_WIDTH+BLANK_WIDTH+DATA_WIDTH-1 -: TAG_WIDTH] = req_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
    req_word[DATA_WIDTH-1:0] = req_data;
  end

  // Next-state logic: accept, issue AW/W independently, then wait for B.
  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    err_d     = err_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
`ifdef DRAM_CACHE_FILL_RR_EN
    rr_d      = rr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          awaddr_d  = req_addr & IDX_MASK;
          wdata_d   = req_word;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = S_ISSUE;
`ifdef DRAM_CACHE_FILL_RR_EN
          rr_d      = ~rr_q;
`endif
        end
      end
      S_ISSUE: begin
        if (awvalid_q && awready_i) awvalid_d = 1'b0;
        if (wvalid_q && wready_i)   wvalid_d  = 1'b0;
        aw_done_d = aw_fin;
        w_done_d  = w_fin;
        if (aw_fin && w_fin) state_d = S_RESP;
      end
      S_RESP: begin
        if (bvalid_i) begin
          err_d   = err_q | (bresp_i != 2'b00);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and payload registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_q     <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
`ifdef DRAM_CACHE_FILL_RR_EN
      rr_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      err_q     <= err_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
`ifdef DRAM_CACHE_FILL_RR_EN
      rr_q      <= rr_d;
`endif
    end
  end

  assign awid_o    = ID_WIDTH'(WR_ID);
  assign awaddr_o  = awaddr_q;
  assign awvalid_o = awvalid_q;
  assign wdata_o   = wdata_q;
  assign wlast_o   = 1'b1;
  assign wvalid_o  = wvalid_q;
  assign bready_o  = (state_q == S_RESP);
  assign busy_o    = (state_q != S_IDLE);
  assign err_o     = err_q;

  // The write ID is single-valued, so the returned ID carries no information.
  assign unused_bid = ^bid_i;

endmodule

// File: tb/tb_dram_cache_fill_writer.sv
// Randomized bench for dram_cache_fill_writer: a transaction-level model
// predicts every output each cycle; directed sections pin literal values.
module tb_dram_cache_fill_writer;
  localparam int AW = 32;
  localparam int DW = 512;
  localparam int IW = 4;
  localparam int WW = 32 + DW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fill_valid_i = 1'b0, refill_valid_i = 1'b0;
  logic fill_ready_o, refill_ready_o;
  logic [AW+DW-1:0] fill_data_i = '0, refill_data_i = '0;
  logic [IW-1:0] awid_o;
  logic [AW-1:0] awaddr_o;
  logic awvalid_o, awready_i = 1'b0;
  logic [WW-1:0] wdata_o;
  logic wlast_o, wvalid_o, wready_i = 1'b0;
  logic [IW-1:0] bid_i = '0;
  logic [1:0] bresp_i = 2'b00;
  logic bvalid_i = 1'b0, bready_o, busy_o, err_o;

  dram_cache_fill_writer dut (
    .clk(clk), .rst_n(rst_n),
    .fill_valid_i(fill_valid_i), .fill_ready_o(fill_ready_o), .fill_data_i(fill_data_i),
    .refill_valid_i(refill_valid_i), .refill_ready_o(refill_ready_o), .refill_data_i(refill_data_i),
    .awid_o(awid_o), .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wdata_o(wdata_o), .wlast_o(wlast_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
    .bid_i(bid_i), .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_busy = 0, m_aw = 0, m_w = 0, m_resp = 0, m_err = 0;
`ifdef DRAM_CACHE_FILL_RR_EN
  bit m_rr = 0;   // 0: fill's turn
`endif
  logic [AW-1:0] m_awaddr = '0;
  logic [WW-1:0] m_wdata = '0;
  int n_fill = 0, n_refill = 0;
  bit acc_log[$];  // 1 = fill accepted, 0 = refill accepted

  function automatic logic [WW-1:0] encode(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit dirty);
    logic [11:0] tag;
    tag = a[31:20];
    return {1'b1, dirty, tag, 18'd0, d};
  endfunction

  function automatic logic [AW-1:0] slot(input logic [AW-1:0] a);
    return ((a / 64) % 16384) * 64;
  endfunction

  function automatic bit want_fill(input bit fv, input bit rv);
    if (fv && rv) begin
`ifdef DRAM_CACHE_FILL_RR_EN
      return !m_rr;
`else
      return 1'b0;
`endif
    end
    return fv;
  endfunction

  function automatic logic [DW-1:0] rnd_line();
    logic [DW-1:0] v;
    for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Model advances on each rising edge from the bench-driven inputs only.
  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      m_busy = 0; m_aw = 0; m_w = 0; m_resp = 0; m_err = 0;
      m_awaddr = '0; m_wdata = '0;
`ifdef DRAM_CACHE_FILL_RR_EN
      m_rr = 0;
`endif
    end else if (!m_busy) begin
      if (fill_valid_i || refill_valid_i) begin
        bit gf;
        logic [AW+DW-1:0] p;
        gf = want_fill(fill_valid_i, refill_valid_i);
        p = gf ? fill_data_i : refill_data_i;
        m_awaddr = slot(p[AW+DW-1:DW]);
        m_wdata  = encode(p[AW+DW-1:DW], p[DW-1:0], gf);
        m_busy = 1; m_aw = 1; m_w = 1;
        acc_log.push_back(gf);
        if (gf) n_fill++; else n_refill++;
`ifdef DRAM_CACHE_FILL_RR_EN
        m_rr = !m_rr;
`endif
      end
    end else if (!m_resp) begin
      if (awready_i) m_aw = 0;
      if (wready_i)  m_w = 0;
      if (!m_aw && !m_w) m_resp = 1;
    end else if (bvalid_i) begin
      if (bresp_i != 2'b00) m_err = 1;
      m_busy = 0; m_resp = 0;
    end
  end

  // Compare every output against the model on each falling edge.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      bit gf;
      gf = want_fill(fill_valid_i, refill_valid_i);
      chk("fill_ready", fill_ready_o, !m_busy && fill_valid_i && gf);
      chk("refill_ready", refill_ready_o, !m_busy && refill_valid_i && !gf);
      chk("busy", busy_o, m_busy);
      chk("awvalid", awvalid_o, m_aw);
      chk("wvalid", wvalid_o, m_w);
      chk("bready", bready_o, m_resp);
      chk("err", err_o, m_err);
      chk("awaddr", awaddr_o, m_awaddr);
      chk("wdata", wdata_o, m_wdata);
      chk("awid", awid_o, 0);
      chk("wlast", wlast_o, 1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    @(negedge clk);
    while (busy_o && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (busy_o) begin
      checks++; errors++;
      $display("FAIL %s timeout busy=%0b required=0", nm, busy_o);
    end
    tick();
  endtask

  logic [DW-1:0] pat_a;
  logic [7:0] order_got;
  int base_f, base_r, base_log, cyc;

  initial begin
    pat_a = {16{32'hA5A5_0F0F}};
    tick(); tick();
    rst_n = 1'b1;
    chk_en = 1'b1;

    // reset values
    @(negedge clk);
    chk("rst_awvalid", awvalid_o, 0);
    chk("rst_wvalid", wvalid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_wdata", wdata_o, 0);
    chk("rst_awaddr", awaddr_o, 0);
    tick();

    // both ports valid for 4 requests each
    awready_i = 1; wready_i = 1; bvalid_i = 1; bresp_i = 0;
    base_f = n_fill; base_r = n_refill; base_log = acc_log.size();
    cyc = 0;
    while ((n_fill < base_f + 4 || n_refill < base_r + 4) && cyc < 100) begin
      fill_valid_i   = (n_fill < base_f + 4);
      refill_valid_i = (n_refill < base_r + 4);
      fill_data_i    = {$urandom, rnd_line()};
      refill_data_i  = {$urandom, rnd_line()};
      tick();
      cyc++;
    end
    fill_valid_i = 0; refill_valid_i = 0;
    order_got = '0;
    if (acc_log.size() >= base_log + 8)
      for (int i = 0; i < 8; i++) order_got[7-i] = acc_log[base_log + i];
`ifdef DRAM_CACHE_FILL_RR_EN
    chk("grant_order", order_got, 8'b1010_1010);
`else
    chk("grant_order", order_got, 8'b0000_1111);
`endif
    wait_idle("grant_drain");

    // directed fill with literal encoding
    fill_data_i = {32'h1234_5640, pat_a};
    fill_valid_i = 1;
    tick();
    fill_valid_i = 0;
    @(negedge clk);
    chk("dir_awaddr", awaddr_o, 32'h0004_5640);
    chk("dir_vd_tag", wdata_o[543:530], {2'b11, 12'h123});
    chk("dir_blank", wdata_o[529:512], 0);
    chk("dir_data", wdata_o[511:0], pat_a);
    chk("model_enc", m_wdata, {2'b11, 12'h123, 18'h0, pat_a});
    chk("model_slot", m_awaddr, 32'h0004_5640);
    wait_idle("dir_fill");

    // refill of the same address is clean
    refill_data_i = {32'h1234_5640, pat_a};
    refill_valid_i = 1;
    tick();
    refill_valid_i = 0;
    @(negedge clk);
    chk("refill_valid_bit", wdata_o[543], 1);
    chk("refill_dirty_bit", wdata_o[542], 0);
    wait_idle("dir_refill");

    // W held off for 5 cycles while AW completes immediately
    wready_i = 0;
    fill_data_i = {$urandom, rnd_line()};
    fill_valid_i = 1;
    tick();
    fill_valid_i = 0;
    @(negedge clk);
    chk("stall_aw_first", awvalid_o, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      chk("stall_aw_low", awvalid_o, 0);
      chk("stall_w_high", wvalid_o, 1);
      chk("stall_no_resp", bready_o, 0);
      chk("stall_wdata", wdata_o, encode(fill_data_i[AW+DW-1:DW], fill_data_i[DW-1:0], 1'b1));
    end
    tick();
    wready_i = 1;
    tick();
    @(negedge clk);
    chk("stall_resp", bready_o, 1);
    wait_idle("stall");

    // error response is sticky
    bresp_i = 2'b10;
    fill_data_i = {$urandom, rnd_line()};
    fill_valid_i = 1;
    tick();
    fill_valid_i = 0;
    wait_idle("err_write");
    @(negedge clk);
    chk("err_set", err_o, 1);
    tick();
    bresp_i = 2'b00;
    refill_data_i = {$urandom, rnd_line()};
    refill_valid_i = 1;
    tick();
    refill_valid_i = 0;
    wait_idle("err_ok_write");
    @(negedge clk);
    chk("err_sticky", err_o, 1);
    tick();

    // reset while in the issue phase
    awready_i = 0; wready_i = 0;
    fill_data_i = {$urandom, rnd_line()};
    fill_valid_i = 1;
    tick();
    fill_valid_i = 0;
    @(negedge clk);
    chk("mid_busy", busy_o, 1);
    tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    @(negedge clk);
    chk("mid_rst_aw", awvalid_o, 0);
    chk("mid_rst_w", wvalid_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_err", err_o, 0);
    tick();
    awready_i = 1; wready_i = 1; bvalid_i = 1;
    fill_data_i = {32'hFEDC_BA98, pat_a};
    fill_valid_i = 1;
    tick();
    fill_valid_i = 0;
    @(negedge clk);
    chk("post_rst_aw", awvalid_o, 1);
    chk("post_rst_addr", awaddr_o, 32'h000C_BA80);
    wait_idle("post_rst");

    // randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      fill_valid_i   = ($urandom % 2) == 0;
      refill_valid_i = ($urandom % 2) == 0;
      fill_data_i    = {$urandom, rnd_line()};
      refill_data_i  = {$urandom, rnd_line()};
      awready_i      = ($urandom % 10) < 7;
      wready_i       = ($urandom % 10) < 7;
      bvalid_i       = ($urandom % 10) < 6;
      bresp_i        = (($urandom % 8) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      bid_i          = IW'($urandom);
      rst_n          = ($urandom % 200) != 0;
      tick();
    end
    rst_n = 1;
    fill_valid_i = 0; refill_valid_i = 0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
